imem_burst_sched: RTL and testbench

//  Sequences a single-port instruction SRAM on behalf of two engine fetch ports (port1, port2).

---
 rtl/imem_burst_sched.sv | 154 +++++++++++++++
 tb/tb_imem_burst_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_burst_sched.sv
// Single-port instruction SRAM burst sequencer serving two fetch ports with tagged read return.
// Optional macro IMEM_SCHED_FIXED_PRIO_EN: fixed priority (port1 wins) instead of round-robin.
module imem_burst_sched #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 48,
   parameter int unsigned BURST  = 5,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req1,
   input  logic [ADDR_W-1:0] base1,
   output logic              gnt1,
   input  logic              req2,
   input  logic [ADDR_W-1:0] base2,
   output logic              gnt2,
   output logic              sram_ce,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              rd_valid,
   output logic              rd_port,
   output logic [2:0]        rd_idx,
   output logic [DATA_W-1:0] rd_data,
   output logic              done1,
   output logic              done2,
   output logic              busy
);

   localparam int unsigned IDX_W = 3;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nx;
   logic [ADDR_W-1:0] r_addr;
   logic [IDX_W-1:0]  r_idx;
   logic              r_port;
   logic              r_last;
   logic              w_win;
   logic              w_tags_busy;

   logic              r_tag_v [RD_LAT];
   logic              r_tag_p [RD_LAT];
   logic [IDX_W-1:0]  r_tag_i [RD_LAT];

   assign sram_ce   = (r_state == S_ISSUE);
   assign sram_addr = r_addr;

   // Arbitration and next-state; grants only leave IDLE and are masked by reset.
   always_comb begin
      w_state_nx = r_state;
      gnt1       = 1'b0;
      gnt2       = 1'b0;
      w_win      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!reset && (req1 || req2)) begin
               if (req1 && req2) begin
`ifdef IMEM_SCHED_FIXED_PRIO_EN
                  w_win = 1'b0;
`else
                  w_win = ~r_last;
`endif
               end else begin
                  w_win = req2;
               end
               gnt1       = ~w_win;
               gnt2       = w_win;
               w_state_nx = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (r_idx == IDX_W'(BURST - 1)) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      w_tags_busy = 1'b0;
      for (int unsigned k = 0; k < RD_LAT; k++) w_tags_busy = w_tags_busy | r_tag_v[k];
   end

   // Address sequencing and arbitration history.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_idx   <= '0;
         r_port  <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nx;
         if (gnt1 || gnt2) begin
            r_addr <= w_win ? base2 : base1;
            r_idx  <= '0;
            r_port <= w_win;
            r_last <= w_win;
         end else if (r_state == S_ISSUE) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_idx  <= r_idx + IDX_W'(1);
         end
      end
   end

   // Tag pipeline follows each address beat so returned data can be labelled.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned k = 0; k < RD_LAT; k++) begin
            r_tag_v[k] <= 1'b0;
            r_tag_p[k] <= 1'b0;
            r_tag_i[k] <= '0;
         end
      end else begin
         r_tag_v[0] <= (r_state == S_ISSUE);
         r_tag_p[0] <= r_port;
         r_tag_i[0] <= r_idx;
         for (int unsigned k = 1; k < RD_LAT; k++) begin
            r_tag_v[k] <= r_tag_v[k-1];
            r_tag_p[k] <= r_tag_p[k-1];
            r_tag_i[k] <= r_tag_i[k-1];
         end
      end
   end

   // Return register: data is captured the cycle its tag reaches the end of the pipe.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_port  <= 1'b0;
         rd_idx   <= '0;
         rd_data  <= '0;
         done1    <= 1'b0;
         done2    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         rd_valid <= r_tag_v[RD_LAT-1];
         done1    <= r_tag_v[RD_LAT-1] && !r_tag_p[RD_LAT-1]
                     && (r_tag_i[RD_LAT-1] == IDX_W'(BURST - 1));
         done2    <= r_tag_v[RD_LAT-1] && r_tag_p[RD_LAT-1]
                     && (r_tag_i[RD_LAT-1] == IDX_W'(BURST - 1));
         if (r_tag_v[RD_LAT-1]) begin
            rd_port <= r_tag_p[RD_LAT-1];
            rd_idx  <= r_tag_i[RD_LAT-1];
            rd_data <= sram_rdata;
         end
         busy <= (w_state_nx == S_ISSUE) || (r_state == S_ISSUE) || w_tags_busy;
      end
   end

endmodule

// File: tb/tb_imem_burst_sched.sv
// Bench for imem_burst_sched: timeline model of grants, address beats and returns, plus directed literals.
// Honours IMEM_SCHED_FIXED_PRIO_EN for the arbitration model.
module tb_imem_burst_sched;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 48;
   localparam int BURST  = 5;
   localparam int RD_LAT = 1;
   localparam int RING   = 16;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              req1 = 1'b0, req2 = 1'b0;
   logic [ADDR_W-1:0] base1 = '0, base2 = '0;
   logic              gnt1, gnt2, sram_ce, rd_valid, rd_port, done1, done2, busy;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_rdata = '0;
   logic [DATA_W-1:0] rd_data;
   logic [2:0]        rd_idx;

   int total = 0;
   int bad   = 0;

   imem_burst_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST), .RD_LAT(RD_LAT)) dut (
      .clock(clock), .reset(reset),
      .req1(req1), .base1(base1), .gnt1(gnt1),
      .req2(req2), .base2(base2), .gnt2(gnt2),
      .sram_ce(sram_ce), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
      .rd_valid(rd_valid), .rd_port(rd_port), .rd_idx(rd_idx), .rd_data(rd_data),
      .done1(done1), .done2(done2), .busy(busy)
   );

   always #5 clock = ~clock;

   function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      return {a, 6'h2A, ~a, {a, a, 2'b01}};
   endfunction

   // SRAM with one cycle read latency
   always @(posedge clock) if (sram_ce) sram_rdata <= mem_word(sram_addr);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected-output timeline, indexed by cycle modulo RING
   logic              e_ce   [RING];
   logic [ADDR_W-1:0] e_addr [RING];
   logic              e_rv   [RING];
   logic              e_port [RING];
   logic [2:0]        e_idx  [RING];
   logic [DATA_W-1:0] e_data [RING];
   logic              e_d1   [RING];
   logic              e_d2   [RING];
   logic              e_busy [RING];

   task automatic clr(input int s);
      e_ce[s] = 0; e_addr[s] = '0; e_rv[s] = 0; e_port[s] = 0; e_idx[s] = '0;
      e_data[s] = '0; e_d1[s] = 0; e_d2[s] = 0; e_busy[s] = 0;
   endtask

   initial begin : compare
      int cyc, m_free, s, t;
      logic m_last, win, grant, eg1, eg2;
      logic [ADDR_W-1:0] b, a;
      for (int i = 0; i < RING; i++) clr(i);
      cyc = 0; m_free = 0; m_last = 1'b1;
      @(posedge clock);
      forever begin
         @(negedge clock);
         s = cyc % RING;
         grant = 0; win = 0;
         if (!reset && cyc >= m_free && (req1 || req2)) begin
            grant = 1;
            if (req1 && req2) begin
`ifdef IMEM_SCHED_FIXED_PRIO_EN
               win = 1'b0;
`else
               win = m_last ? 1'b0 : 1'b1;
`endif
            end else begin
               win = req2;
            end
         end
         eg1 = grant && !win;
         eg2 = grant && win;
         chk("gnt1", 64'(gnt1), 64'(eg1));
         chk("gnt2", 64'(gnt2), 64'(eg2));
         chk("sram_ce", 64'(sram_ce), 64'(e_ce[s]));
         if (e_ce[s]) chk("sram_addr", 64'(sram_addr), 64'(e_addr[s]));
         chk("rd_valid", 64'(rd_valid), 64'(e_rv[s]));
         if (e_rv[s]) begin
            chk("rd_port", 64'(rd_port), 64'(e_port[s]));
            chk("rd_idx", 64'(rd_idx), 64'(e_idx[s]));
            chk("rd_data", 64'(rd_data), 64'(e_data[s]));
         end
         chk("done1", 64'(done1), 64'(e_d1[s]));
         chk("done2", 64'(done2), 64'(e_d2[s]));
         chk("busy", 64'(busy), 64'(e_busy[s]));
         clr(s);
         if (reset) begin
            for (int i = 0; i < RING; i++) clr(i);
            m_free = cyc + 1;
            m_last = 1'b1;
         end else if (grant) begin
            b = win ? base2 : base1;
            for (int k = 0; k < BURST; k++) begin
               a = ADDR_W'(b + ADDR_W'(k));
               t = (cyc + 1 + k) % RING;
               e_ce[t] = 1; e_addr[t] = a;
               t = (cyc + 2 + RD_LAT + k) % RING;
               e_rv[t] = 1; e_port[t] = win; e_idx[t] = 3'(k); e_data[t] = mem_word(a);
               e_d1[t] = (k == BURST - 1) && !win;
               e_d2[t] = (k == BURST - 1) && win;
            end
            for (int d = 1; d <= BURST + RD_LAT + 1; d++) e_busy[(cyc + d) % RING] = 1;
            m_free = cyc + BURST + 1;
            m_last = win;
         end
         cyc++;
      end
   end

   task automatic tick(); @(posedge clock); #1; endtask
   task automatic mid();  @(negedge clock); endtask
   task automatic adv(input int n); repeat (n) begin tick(); mid(); end endtask

   initial begin : stim
      int gl [$];
      logic seen;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      mid();
      chk("rst_rd_valid", 64'(rd_valid), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_addr", 64'(sram_addr), 64'h0);
      chk("rst_rd_data", 64'(rd_data), 64'h0);

      // Single port1 burst
      tick(); req1 = 1; base1 = 10'h010; mid();
      chk("t1_gnt1", 64'(gnt1), 64'h1);
      tick(); req1 = 0; mid();
      chk("t1_addr_first", 64'(sram_addr), 64'h010);
      adv(2);
      chk("t1_rv_first", 64'(rd_valid), 64'h1);
      chk("t1_idx_first", 64'(rd_idx), 64'h0);
      adv(2);
      chk("t1_addr_last", 64'(sram_addr), 64'h014);
      adv(1);
      chk("t1_ce_off", 64'(sram_ce), 64'h0);
      adv(1);
      chk("t1_done1", 64'(done1), 64'h1);
      chk("t1_idx_last", 64'(rd_idx), 64'h4);
      adv(1);
      chk("t1_busy_off", 64'(busy), 64'h0);

      // Simultaneous requests right after reset
      tick(); reset = 1; mid();
      tick(); reset = 0; req1 = 1; req2 = 1; base1 = 10'h020; base2 = 10'h100; mid();
      chk("t2_gnt1", 64'(gnt1), 64'h1);
      chk("t2_gnt2_lose", 64'(gnt2), 64'h0);
      tick(); req1 = 0; mid();
      adv(5);
      chk("t2_gnt2", 64'(gnt2), 64'h1);
      tick(); req2 = 0; mid();
      chk("t2_addr", 64'(sram_addr), 64'h100);
      adv(6);
      chk("t2_done2", 64'(done2), 64'h1);
      chk("t2_port", 64'(rd_port), 64'h1);
      adv(3);

      // Both held for four bursts
      tick(); req1 = 1; req2 = 1; base1 = 10'h040; base2 = 10'h2C0; mid();
      for (int i = 0; i < 24; i++) begin
         if (i > 0) begin tick(); mid(); end
         if (gnt1) gl.push_back(1);
         if (gnt2) gl.push_back(2);
      end
      chk("t3_ngrants", 64'(gl.size()), 64'd4);
      for (int i = 0; i < gl.size() && i < 4; i++) begin
`ifdef IMEM_SCHED_FIXED_PRIO_EN
         chk("t6_order", 64'(gl[i]), 64'd1);
`else
         chk("t3_order", 64'(gl[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
`endif
      end
      tick(); req1 = 0; mid();
      chk("t3_gnt2_after_drop", 64'(gnt2), 64'h1);
      tick(); req2 = 0; mid();
      adv(8);

      // Address wrap
      tick(); req1 = 1; base1 = 10'h3FE; mid();
      tick(); req1 = 0; mid();
      chk("t4_a0", 64'(sram_addr), 64'h3FE);
      adv(1); chk("t4_a1", 64'(sram_addr), 64'h3FF);
      adv(1); chk("t4_a2", 64'(sram_addr), 64'h000);
      adv(1); chk("t4_a3", 64'(sram_addr), 64'h001);
      adv(6);

      // Reset mid-burst
      tick(); req1 = 1; base1 = 10'h055; mid();
      tick(); req1 = 0; mid();
      adv(1);
      tick(); reset = 1; mid();
      chk("t5_beat3", 64'(sram_addr), 64'h057);
      tick(); reset = 0; mid();
      chk("t5_ce_off", 64'(sram_ce), 64'h0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (rd_valid || done1) seen = 1;
         tick(); mid();
      end
      chk("t5_no_return", 64'(seen), 64'h0);
      tick(); req1 = 1; base1 = 10'h200; mid();
      chk("t5_fresh_gnt1", 64'(gnt1), 64'h1);
      tick(); req1 = 0; mid();
      chk("t5_fresh_addr", 64'(sram_addr), 64'h200);
      adv(8);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         tick();
         req1  = ($urandom_range(0, 99) < 55);
         req2  = ($urandom_range(0, 99) < 55);
         base1 = ADDR_W'($urandom);
         base2 = ADDR_W'($urandom);
         reset = ($urandom_range(0, 249) == 0);
      end
      tick(); reset = 0; req1 = 0; req2 = 0;
      adv(15);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
